// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - frame accumulator for Booth products; define ACCUM_SAT_EN for saturating sums
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      clear and begin a new frame
//   prod_in/valid/ready        signed product input stream
//   acc_out/valid/ready        signed frame sum output, held until accepted
//   busy                       frame in progress or result pending
//   overflow                   sticky signed overflow for the current frame
module booth_product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;

    logic                beat;
    logic                clear;
    logic                last_beat;
    logic [ACC_W-1:0]    addend;
    logic [ACC_W-1:0]    raw_sum;
    logic                sum_ovf;
    logic [ACC_W-1:0]    acc_step;

    // Sized cast of a signed operand sign-extends the product to ACC_W.
    assign addend    = ACC_W'($signed(prod_in));
    assign raw_sum   = acc_q + addend;
    // Signed overflow: operands agree in sign but the result does not.
    assign sum_ovf   = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                       (raw_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef ACCUM_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // The overflow direction follows the sign shared by both operands.
    assign acc_step = sum_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw_sum;
`else
    assign acc_step = raw_sum;
`endif

    assign beat      = prod_valid && prod_ready;
    assign last_beat = beat && (cnt_q == CNT_W'(FRAME_LEN - 1));
    // start is ignored in HOLD unless the pending result is accepted.
    assign clear     = start && ((state_q != S_HOLD) || acc_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (!start && last_beat) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (acc_ready) begin
                    state_d = start ? S_ACC : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            S_ACC: begin
                prod_ready = !start;
                busy       = 1'b1;
            end
            S_HOLD: begin
                acc_valid  = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                prod_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (beat) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            ovf_q <= ovf_q | sum_ovf;
        end
    end

    assign acc_out  = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - scoreboard bench for booth_product_accumulator
module tb_booth_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic [15:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic        busy;
    logic        overflow;

    logic        b_start;
    logic [7:0]  b_prod_in;
    logic        b_prod_valid;
    logic        b_prod_ready;
    logic [7:0]  b_acc_out;
    logic        b_acc_valid;
    logic        b_acc_ready;
    logic        b_busy;
    logic        b_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    logic [16:0] exp_q[$];
    logic [8:0]  exp8_q[$];

    always #5 clk = ~clk;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .overflow(overflow)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .prod_in(b_prod_in), .prod_valid(b_prod_valid), .prod_ready(b_prod_ready),
        .acc_out(b_acc_out), .acc_valid(b_acc_valid), .acc_ready(b_acc_ready),
        .busy(b_busy), .overflow(b_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (acc_valid && acc_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result16", {15'd0, overflow, acc_out}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("result16_acc", {16'd0, acc_out}, {16'd0, e[15:0]});
                chk("result16_ovf", {31'd0, overflow}, {31'd0, e[16]});
            end
        end
    end

    always @(negedge clk) begin
        if (b_acc_valid && b_acc_ready) begin
            if (exp8_q.size() == 0) begin
                chk("unexpected_result8", {23'd0, b_overflow, b_acc_out}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = exp8_q.pop_front();
                chk("result8_acc", {24'd0, b_acc_out}, {24'd0, e[7:0]});
                chk("result8_ovf", {31'd0, b_overflow}, {31'd0, e[8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] p);
        prod_in    = p;
        prod_valid = 1'b1;
        #1;
        chk("beat_ready16", {31'd0, prod_ready}, 32'd1);
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] p);
        b_prod_in    = p;
        b_prod_valid = 1'b1;
        #1;
        chk("beat_ready8", {31'd0, b_prod_ready}, 32'd1);
        tick();
        b_prod_valid = 1'b0;
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 20 && !acc_valid; k++) tick();
        chk("hold_reached16", {31'd0, acc_valid}, 32'd1);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("idle_valid16", {31'd0, acc_valid}, 32'd0);
        chk("idle_busy16", {31'd0, busy}, 32'd0);
    endtask

    task automatic frame8(input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3,
                          input logic [8:0] exp);
        exp8_q.push_back(exp);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        send8(p0); send8(p1); send8(p2); send8(p3);
        for (int k = 0; k < 20 && !b_acc_valid; k++) tick();
        chk("hold_reached8", {31'd0, b_acc_valid}, 32'd1);
        b_acc_ready = 1'b1;
        tick();
        b_acc_ready = 1'b0;
    endtask

    initial begin
        logic       gv[7];
        logic [7:0] gp[7];
        gv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gp = '{8'h01, 8'h55, 8'h66, 8'h02, 8'h03, 8'h77, 8'h04};

        rst_n = 1'b0; start = 1'b0; prod_in = 8'h00; prod_valid = 1'b0; acc_ready = 1'b0;
        b_start = 1'b0; b_prod_in = 8'h00; b_prod_valid = 1'b0; b_acc_ready = 1'b0;
        tick(); tick();
        chk("rst_acc_out", {16'd0, acc_out}, 32'd0);
        chk("rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame, then a long HOLD with acc_ready low.
        exp_q.push_back({1'b0, 16'hFFFA});
        pulse_start();
        send(8'h31); send(8'h C0); send(8'h0F);
        chk("t1_not_yet_valid", {31'd0, acc_valid}, 32'd0);
        send(8'hFA);
        chk("t1_valid_after_last", {31'd0, acc_valid}, 32'd1);
        chk("t1_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", {31'd0, acc_valid}, 32'd1);
            chk("t3_hold_acc", {16'd0, acc_out}, 32'h0000_FFFA);
            chk("t3_hold_prod_ready", {31'd0, prod_ready}, 32'd0);
            tick();
        end
        pulse_start();
        chk("t3_start_ignored_valid", {31'd0, acc_valid}, 32'd1);
        chk("t3_start_ignored_acc", {16'd0, acc_out}, 32'h0000_FFFA);
        finish_frame();

        // Gaps in prod_valid stall the count.
        exp_q.push_back({1'b0, 16'h000A});
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            prod_valid = gv[i];
            prod_in    = gp[i];
            tick();
        end
        prod_valid = 1'b0;
        chk("t4_valid_after_gaps", {31'd0, acc_valid}, 32'd1);
        finish_frame();

        // start mid-frame discards earlier beats and refuses the offered product.
        pulse_start();
        send(8'h05); send(8'h06);
        start = 1'b1; prod_valid = 1'b1; prod_in = 8'h40;
        #1;
        chk("t5_ready_low_on_start", {31'd0, prod_ready}, 32'd0);
        tick();
        start = 1'b0; prod_valid = 1'b0;
        chk("t5_cleared_acc", {16'd0, acc_out}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({1'b0, 16'h0004});
        send(8'h01); send(8'h01); send(8'h01); send(8'h01);
        finish_frame();

        // Asynchronous reset mid-frame.
        pulse_start();
        send(8'h01); send(8'h02);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_acc_out", {16'd0, acc_out}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        chk("t6_rst_acc_valid", {31'd0, acc_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back({1'b0, 16'h0021});
        pulse_start();
        send(8'h10); send(8'h20); send(8'hF0); send(8'h01);
        finish_frame();

        // Accept with start in HOLD restarts immediately.
        exp_q.push_back({1'b0, 16'hFE00});
        pulse_start();
        send(8'h80); send(8'h80); send(8'h80); send(8'h80);
        chk("t7_hold_valid", {31'd0, acc_valid}, 32'd1);
        acc_ready = 1'b1; start = 1'b1;
        tick();
        acc_ready = 1'b0; start = 1'b0;
        #1;
        chk("t7_restart_valid", {31'd0, acc_valid}, 32'd0);
        chk("t7_restart_busy", {31'd0, busy}, 32'd1);
        chk("t7_restart_ready", {31'd0, prod_ready}, 32'd1);
        chk("t7_restart_acc", {16'd0, acc_out}, 32'd0);
        exp_q.push_back({1'b0, 16'h0003});
        send(8'h01); send(8'h01); send(8'h01); send(8'h00);
        finish_frame();

        // Narrow accumulator: positive and negative overflow, then sticky clear.
`ifdef ACCUM_SAT_EN
        frame8(8'h7F, 8'h7F, 8'h00, 8'h00, {1'b1, 8'h7F});
        frame8(8'h80, 8'h80, 8'h01, 8'h00, {1'b1, 8'h81});
`else
        frame8(8'h7F, 8'h7F, 8'h00, 8'h00, {1'b1, 8'hFE});
        frame8(8'h80, 8'h80, 8'h01, 8'h00, {1'b1, 8'h01});
`endif
        frame8(8'h01, 8'h02, 8'h03, 8'h04, {1'b0, 8'h0A});

        tick(); tick();
        chk("scoreboard16_drained", exp_q.size(), 32'd0);
        chk("scoreboard8_drained", exp8_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
